masked_and_driver: RTL and testbench
====================================

Name: masked_and_driver

Overview:
- Initiator for the 2-share masked AND gadget.
- Accepts plaintext bits a and b, encodes each into D Boolean shares using an internal LFSR, and supplies fresh gadget randomness.
- Drives the gadget's enable for its fixed latency, then captures and recombines the output shares into a plaintext result.
- Sits between the test or control logic and the AND gadget in the masked-datapath experiments.

Parameters:
- D, 2, number of shares; must match the gadget.
- RAND_W, D*(D-1)/2, gadget randomness width.
- LAT, 3, number of enabled clock edges the gadget needs before done is valid.
- LFSR_W, 16, LFSR width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled in IDLE only.
- a  in  1  plaintext operand a.
- b  in  1  plaintext operand b.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/err are valid.
- result  out  1  recombined a AND b; held until the next done.
- err  out  1  sticky protocol error; cleared only by reset.
- share_a  out  [0:D-1]  masked a, to gadget ina.
- share_b  out  [0:D-1]  masked b, to gadget inb.
- rin  out  [0:RAND_W-1]  fresh gadget randomness.
- and_enable  out  1  gadget enable (Moore, registered).
- and_done  in  1  gadget done.
- and_out  in  [0:D-1]  gadget output shares.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: state=IDLE, lfsr=LFSR_SEED, share_a=0, share_b=0, rin=0, and_enable=0, busy=0, done=0, result=0, err=0.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, taps mask 16'hB400. It advances exactly one step per cycle in REFRESH only; it never stalls in the all-zero state.
- NEED = 2*(D-1)+RAND_W random bits per operation (3 for D=2).
- FSM states:
  - IDLE: if start is high, latch a and b, go to REFRESH. start in any other state is ignored (no queueing).
  - REFRESH: NEED cycles, stepping the LFSR each cycle, then go to LOAD.
  - LOAD: take bits from the low end of lfsr, in this order:
    - ra[1..D-1] from lfsr[0..D-2];
    - rb[1..D-1] from the next D-1 bits;
    - rin from the next RAND_W bits.
  - LOAD then registers the shares:
    - share_a[i]=ra[i] and share_b[i]=rb[i] for i>=1;
    - share_a[0] = a XOR (XOR of ra[1..D-1]);
    - share_b[0] = b XOR (XOR of rb[1..D-1]).
  - LOAD then goes to RUN.
  - RUN: and_enable=1 for exactly LAT cycles, counted by run_cnt 0..LAT-1. share_a, share_b and rin are held constant. Then go to COLLECT.
  - COLLECT: and_enable=0.
    - At the closing edge, capture result = XOR of all and_out bits.
    - If and_done==0 at that edge, set err=1 and force result=0.
    - The gadget clears its out on this same edge; the driver captures the pre-clear value.
    - Then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE. share_a, share_b and rin keep their last values.
- Latency: start sampled at edge 0 → done high in cycle 1+NEED+1+LAT+1 (9 for defaults).
- Gadget lock-step: and_enable is high for exactly LAT edges per operation, so the gadget's internal counter returns to 0 after each operation.
- Reset mid-operation: the driver returns to IDLE immediately, but the gadget counter (unresettable) may be left mid-count. The next operation then sees and_done==0 in COLLECT, raises err, and resynchronises the gadget. Results are trustworthy only while err==0.
- busy=1 from the cycle after start is accepted until DONE inclusive.

Decomposition:
- Shared package masking_pkg holds:
  - state enum (IDLE, REFRESH, LOAD, RUN, COLLECT, DONE);
  - LFSR_TAPS = 16'hB400;
  - a function for the RAND_W formula;
  - a function share_xor(vector) → XOR reduction.
- One sub-module, masking_lfsr: parameters LFSR_W and LFSR_SEED; ports clk, rst_n, step, state. The driver instantiates it.
- The gadget itself is not instantiated inside the driver; both are wired up at the top level.

Test Plan:
- Reset then a=1, b=1, start pulse, driver wired to the gadget → done at cycle 9, result=1, err=0, and_enable high exactly 3 cycles.
- All four (a,b) pairs, 50 operations each → result equals a&b every time. share_a[0]^share_a[1]==a whenever share_a is checked, and likewise share_b gives b.
- LFSR from seed 16'hACE1 → state after each REFRESH matches the reference model after 3, 6, 9 steps. rin and share bits vary across consecutive operations.
- Gadget replaced by a stub holding and_done=0 → err=1 after the first done, result=0; err remains 1 through later operations until rst_n low.
- rst_n asserted during RUN (second enabled cycle), then a new op with a=1, b=1 → that op flags err=1. A following op after another reset returns result=1 with err=0.
- start held high continuously → one operation per 9+1 cycles, busy never drops except for one IDLE cycle between ops, and no start is accepted while busy.

Source files
------------

// File: rtl/masking_pkg.sv
// rtl/masking_pkg.sv - shared types and helpers for the masked AND driver
package masking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    LOAD,
    RUN,
    COLLECT,
    DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int rand_w(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic logic share_xor(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/masking_lfsr.sv
// rtl/masking_lfsr.sv - Galois LFSR supplying mask and gadget randomness
module masking_lfsr
  import masking_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] shifted;

  always_comb begin
    shifted = state >> 1;
    if (state[0]) shifted = shifted ^ LFSR_W'(LFSR_TAPS);
  end

  // A zero state can only come from an upset; reload the seed rather than lock up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              state <= LFSR_SEED;
    else if (state == '0)    state <= LFSR_SEED;
    else if (step)           state <= shifted;
  end

endmodule

// File: rtl/masked_and_driver.sv
// rtl/masked_and_driver.sv - share encoder, sequencer and recombiner for the masked AND gadget
module masked_and_driver
  import masking_pkg::*;
#(
  parameter int                D         = 2,
  parameter int                RAND_W    = rand_w(D),
  parameter int                LAT       = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            a,
  input  logic            b,
  output logic            busy,
  output logic            done,
  output logic            result,
  output logic            err,
  output logic [0:D-1]    share_a,
  output logic [0:D-1]    share_b,
  output logic [0:RAND_W-1] rin,
  output logic            and_enable,
  input  logic            and_done,
  input  logic [0:D-1]    and_out
);

  localparam int NEED    = 2 * (D - 1) + RAND_W;
  localparam int CNT_MAX = (NEED > LAT) ? NEED : LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   ref_cnt, run_cnt;
  logic               a_q, b_q;
  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_unused;
  logic [0:D-1]       ra, rb, sa_nxt, sb_nxt;
  logic [0:RAND_W-1]  rin_nxt;

  masking_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (state == REFRESH),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:NEED];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REFRESH;
      REFRESH: if (ref_cnt == CNT_W'(NEED - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (run_cnt == CNT_W'(LAT - 1)) state_nxt = COLLECT;
      COLLECT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    and_enable = (state == RUN);
  end

  // Mask bits come from the low end of the LFSR: ra first, then rb, then rin.
  always_comb begin
    ra      = '0;
    rb      = '0;
    rin_nxt = '0;
    for (int i = 1; i < D; i++) begin
      ra[i] = lfsr[i - 1];
      rb[i] = lfsr[D - 1 + i - 1];
    end
    for (int j = 0; j < RAND_W; j++) rin_nxt[j] = lfsr[2 * (D - 1) + j];
    sa_nxt    = ra;
    sb_nxt    = rb;
    sa_nxt[0] = a_q ^ share_xor(32'(ra));
    sb_nxt[0] = b_q ^ share_xor(32'(rb));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      run_cnt <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      share_a <= '0;
      share_b <= '0;
      rin     <= '0;
      result  <= 1'b0;
      err     <= 1'b0;
    end else begin
      ref_cnt <= (state == REFRESH) ? ref_cnt + 1'b1 : '0;
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == LOAD) begin
        share_a <= sa_nxt;
        share_b <= sb_nxt;
        rin     <= rin_nxt;
      end
      // The gadget clears its outputs on this edge; the pre-clear value is captured.
      if (state == COLLECT) begin
        if (and_done) begin
          result <= share_xor(32'(and_out));
        end else begin
          result <= 1'b0;
          err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_masked_and_driver.sv
// tb/tb_masked_and_driver.sv - directed vector bench for masked_and_driver with a behavioural gadget
module tb_masked_and_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       stub = 1'b0;
  logic       busy, done, result, err, and_enable;
  logic [0:1] share_a, share_b, and_out, dom;
  logic [0:0] rin;
  logic       and_done;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mdl;

  always #5 clk = ~clk;

  masked_and_driver u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .err        (err),
    .share_a    (share_a),
    .share_b    (share_b),
    .rin        (rin),
    .and_enable (and_enable),
    .and_done   (and_done),
    .and_out    (and_out)
  );

  // Behavioural 2-share DOM AND gadget with an unresettable 2-bit enable counter.
  logic [1:0] g_cnt = 2'd0;
  logic [0:1] g_out = 2'b00;
  assign dom[0]   = (share_a[0] & share_b[0]) ^ ((share_a[0] & share_b[1]) ^ rin[0]);
  assign dom[1]   = (share_a[1] & share_b[1]) ^ ((share_a[1] & share_b[0]) ^ rin[0]);
  assign and_done = stub ? 1'b0 : (g_cnt == 2'd3);
  assign and_out  = g_out;

  always @(posedge clk) begin
    if (and_enable) begin
      if (g_cnt == 2'd2) g_out <= dom;
      g_cnt <= g_cnt + 2'd1;
    end else if (g_cnt == 2'd3) begin
      g_cnt <= 2'd0;
      g_out <= 2'b00;
    end
  end

  typedef struct {
    logic a;
    logic b;
    logic exp_r;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mdl   = 16'hACE1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input logic ia, input logic ib, output logic r, output logic e,
                        output int lat, output int en_n);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    en_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (and_enable) en_n++;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = result;
    e = err;
    for (int s = 0; s < 3; s++) mdl = lstep(mdl);
  endtask

  task automatic check_shares(input logic ia, input logic ib);
    check("share_a_recombine", 32'(share_a[0] ^ share_a[1]), 32'(ia));
    check("share_b_recombine", 32'(share_b[0] ^ share_b[1]), 32'(ib));
    check("share_a1_from_lfsr", 32'(share_a[1]), 32'(mdl[0]));
    check("share_b1_from_lfsr", 32'(share_b[1]), 32'(mdl[1]));
    check("rin_from_lfsr", 32'(rin[0]), 32'(mdl[2]));
    check("lfsr_state", 32'(u_dut.lfsr), 32'(mdl));
  endtask

  initial begin
    logic r, e;
    int   lat, en_n;
    logic rin_seen0, rin_seen1, sa_seen0, sa_seen1;
    int   done_cyc[$];
    int   idle_cnt;

    tbl[0] = '{a: 1'b0, b: 1'b0, exp_r: 1'b0};
    tbl[1] = '{a: 1'b0, b: 1'b1, exp_r: 1'b0};
    tbl[2] = '{a: 1'b1, b: 1'b0, exp_r: 1'b0};
    tbl[3] = '{a: 1'b1, b: 1'b1, exp_r: 1'b1};
    mdl = 16'hACE1;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_err", 32'(err), 0);
    check("rst_and_enable", 32'(and_enable), 0);
    check("rst_share_a", 32'(share_a), 0);
    check("rst_share_b", 32'(share_b), 0);
    check("rst_rin", 32'(rin), 0);
    check("rst_lfsr", 32'(u_dut.lfsr), 32'hACE1);
    rst_n = 1'b1;

    run_op(1'b1, 1'b1, r, e, lat, en_n);
    check("first_latency", 32'(lat), 9);
    check("first_enable_cycles", 32'(en_n), 3);
    check("first_result", 32'(r), 1);
    check("first_err", 32'(e), 0);
    check_shares(1'b1, 1'b1);

    rin_seen0 = 1'b0; rin_seen1 = 1'b0; sa_seen0 = 1'b0; sa_seen1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 50; j++) begin
        run_op(tbl[i].a, tbl[i].b, r, e, lat, en_n);
        check("tbl_latency", 32'(lat), 9);
        check("tbl_enable_cycles", 32'(en_n), 3);
        check("tbl_result", 32'(r), 32'(tbl[i].exp_r));
        check("tbl_err", 32'(e), 0);
        check_shares(tbl[i].a, tbl[i].b);
        if (rin[0]) rin_seen1 = 1'b1; else rin_seen0 = 1'b1;
        if (share_a[1]) sa_seen1 = 1'b1; else sa_seen0 = 1'b1;
      end
    end
    check("rin_varies", 32'({rin_seen0, rin_seen1}), 32'b11);
    check("share_a1_varies", 32'({sa_seen0, sa_seen1}), 32'b11);

    // Gadget that never reports done: error is sticky until reset.
    stub = 1'b1;
    run_op(1'b1, 1'b1, r, e, lat, en_n);
    check("stub_err", 32'(e), 1);
    check("stub_result", 32'(r), 0);
    stub = 1'b0;
    run_op(1'b1, 1'b1, r, e, lat, en_n);
    check("stub_err_sticky", 32'(e), 1);
    check("stub_after_result", 32'(r), 1);
    do_reset();
    check("stub_err_cleared", 32'(err), 0);

    // Reset in the second RUN cycle leaves the gadget counter one step ahead.
    @(negedge clk);
    a = 1'b1; b = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_enable_before", 32'(and_enable), 1);
    rst_n = 1'b0;
    mdl   = 16'hACE1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_enable", 32'(and_enable), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 1'b1, r, e, lat, en_n);
    check("midrst_err", 32'(e), 1);
    check("midrst_result", 32'(r), 0);
    do_reset();
    run_op(1'b1, 1'b1, r, e, lat, en_n);
    check("resync_result", 32'(r), 1);
    check("resync_err", 32'(e), 0);
    check("resync_latency", 32'(lat), 9);
    check_shares(1'b1, 1'b1);

    // start held high: one op per ten cycles, one IDLE cycle between ops.
    @(negedge clk);
    a = 1'b1; b = 1'b0; start = 1'b1;
    idle_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) done_cyc.push_back(c);
      if (!busy && c <= 29) idle_cnt++;
    end
    start = 1'b0;
    check("cont_done_count", 32'(done_cyc.size()), 4);
    if (done_cyc.size() >= 3) begin
      check("cont_first_done", 32'(done_cyc[0]), 9);
      check("cont_spacing_1", 32'(done_cyc[1] - done_cyc[0]), 10);
      check("cont_spacing_2", 32'(done_cyc[2] - done_cyc[1]), 10);
    end
    check("cont_idle_cycles", 32'(idle_cnt), 2);
    check("cont_result", 32'(result), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
